// File: rtl/rom_port_arbiter_pkg.sv
// Shared definitions for the ROM port arbiter.
//  - FSM state encoding (IDLE / ACCESS / RESP)
//  - owner encoding (OWN_CPU / OWN_DMA)
//  - default address / data widths
//  - owner_onehot(): owner -> per-port select vector (bit 0 = CPU, bit 1 = DMA)
package rom_port_arbiter_pkg;

  localparam int DEF_AW = 19;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  function automatic logic [1:0] owner_onehot(input owner_e o);
    return (o == OWN_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the two requesters, the ROM and the arbiter.
//  master : requester/ROM side (drives strobes, addresses and ROM read data)
//  slave  : arbiter side (drives acks, read data, ROM address/select, busy)
//  cpu_stb/cpu_addr, dma_stb/dma_addr : 1-cycle request strobes + addresses
//  cpu_ack/cpu_rdata, dma_ack/dma_rdata : 1-cycle ack + held read data
//  mem_addr/mem_cs/mem_rdata : ROM read port, busy : arbiter activity
interface rom_port_arbiter_if #(
  parameter int AW = rom_port_arbiter_pkg::DEF_AW,
  parameter int DW = rom_port_arbiter_pkg::DEF_DW
);
  logic          cpu_stb;
  logic [AW-1:0] cpu_addr;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          dma_stb;
  logic [AW-1:0] dma_addr;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_cs;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport master (
    output cpu_stb, cpu_addr, dma_stb, dma_addr, mem_rdata,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata, mem_addr, mem_cs, busy
  );

  modport slave (
    input  cpu_stb, cpu_addr, dma_stb, dma_addr, mem_rdata,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata, mem_addr, mem_cs, busy
  );
endinterface

// File: rtl/rom_port_arbiter_pick.sv
// Combinational winner select for the ROM port arbiter.
//  cpu_pend, dma_pend : pending request flags
//  starve             : consecutive CPU grants taken while DMA was waiting
//  valid              : some request is pending
//  owner              : CPU normally; DMA if it is alone or has been starved
//                       STARVE_MAX times in a row
module rom_port_arbiter_pick
  import rom_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SW         = 4
) (
  input  logic          cpu_pend,
  input  logic          dma_pend,
  input  logic [SW-1:0] starve,
  output logic          valid,
  output owner_e        owner
);

  always_comb begin
    valid = cpu_pend | dma_pend;
    owner = OWN_CPU;
    if (dma_pend && (!cpu_pend || starve == SW'(STARVE_MAX)))
      owner = OWN_DMA;
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one ROM read port between the CPU fetch port (priority) and the DMA
// block-copy port. Each port captures a strobed request into a pending flag
// and address register; the FSM (IDLE -> ACCESS -> RESP) holds mem_addr for
// RD_LAT cycles, samples mem_rdata into the winner's read-data register and
// acks the winner for one cycle.
//  fclk : clock            rst : asynchronous active-high reset
//  bus  : slave side of rom_port_arbiter_if (requester ports + ROM port + busy)
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 fclk,
  input  logic                 rst,
  rom_port_arbiter_if.slave    bus
);

  localparam int         SW       = 4;
  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_e        state_reg, state_next;
  owner_e        owner_reg, owner_next;
  logic [2:0]    cnt_reg, cnt_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic [1:0]    pend_reg, pend_next;
  logic [AW-1:0] addr_reg [2];
  logic [AW-1:0] addr_next [2];
  logic [DW-1:0] rdata_reg [2];
  logic [DW-1:0] rdata_next [2];

  // Port index 0 = CPU, 1 = DMA throughout.
  logic [1:0]    stb, accept, ack, own_oh, win_oh;
  logic [AW-1:0] req_addr [2];
  logic          pick_valid, grant, capture;
  owner_e        pick_owner;

  assign stb         = {bus.dma_stb, bus.cpu_stb};
  assign req_addr[0] = bus.cpu_addr;
  assign req_addr[1] = bus.dma_addr;
  assign own_oh      = owner_onehot(owner_reg);
  assign win_oh      = owner_onehot(pick_owner);

  rom_port_arbiter_pick #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_pick (
    .cpu_pend (pend_reg[0]),
    .dma_pend (pend_reg[1]),
    .starve   (starve_reg),
    .valid    (pick_valid),
    .owner    (pick_owner)
  );

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    cnt_next      = cnt_reg;
    mem_addr_next = mem_addr_reg;
    starve_next   = starve_reg;
    grant         = 1'b0;
    capture       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          grant         = 1'b1;
          owner_next    = pick_owner;
          mem_addr_next = (pick_owner == OWN_DMA) ? addr_reg[1] : addr_reg[0];
          cnt_next      = CNT_INIT;
          state_next    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_reg == 3'd0) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    // Starvation count only means something while DMA is waiting.
    if (!pend_reg[1])
      starve_next = '0;
    else if (grant && pick_owner == OWN_DMA)
      starve_next = '0;
    else if (grant && starve_reg != SW'(STARVE_MAX))
      starve_next = starve_reg + 1'b1;
  end

  // Per-port capture. A strobe is dropped while its port is pending or being
  // accessed; the RESP cycle of that port already counts as free, so a
  // requester can chain back-to-back reads by strobing on its ack.
  // Accept and grant-clear never coincide: one needs pend=0, the other pend=1.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign accept[gi]     = stb[gi] && !pend_reg[gi] &&
                            !(state_reg == ST_ACCESS && own_oh[gi]);
    assign pend_next[gi]  = accept[gi] | (pend_reg[gi] & ~(grant & win_oh[gi]));
    assign addr_next[gi]  = accept[gi] ? req_addr[gi] : addr_reg[gi];
    assign rdata_next[gi] = (capture && own_oh[gi]) ? bus.mem_rdata : rdata_reg[gi];
    assign ack[gi]        = (state_reg == ST_RESP) && own_oh[gi];
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= OWN_CPU;
      cnt_reg      <= '0;
      starve_reg   <= '0;
      mem_addr_reg <= '0;
      pend_reg     <= '0;
      for (int i = 0; i < 2; i++) begin
        addr_reg[i]  <= '0;
        rdata_reg[i] <= '0;
      end
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      cnt_reg      <= cnt_next;
      starve_reg   <= starve_next;
      mem_addr_reg <= mem_addr_next;
      pend_reg     <= pend_next;
      for (int i = 0; i < 2; i++) begin
        addr_reg[i]  <= addr_next[i];
        rdata_reg[i] <= rdata_next[i];
      end
    end
  end

  assign bus.cpu_ack   = ack[0];
  assign bus.dma_ack   = ack[1];
  assign bus.cpu_rdata = rdata_reg[0];
  assign bus.dma_rdata = rdata_reg[1];
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_cs    = (state_reg == ST_ACCESS);
  assign bus.busy      = (state_reg != ST_IDLE) || (|pend_reg);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic against a timeline model of the arbiter.
module tb_rom_port_arbiter;

  localparam int RD_LAT = 2;
  localparam int SMAX   = 4;

  logic fclk = 1'b0;
  logic rst  = 1'b1;

  rom_port_arbiter_if #(.AW(19), .DW(8)) bus ();

  rom_port_arbiter #(
    .AW(19), .DW(8), .RD_LAT(RD_LAT), .STARVE_MAX(SMAX)
  ) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 fclk = ~fclk;

  function automatic logic [7:0] rom(input logic [18:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  assign bus.mem_rdata = rom(bus.mem_addr);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- timeline reference model ----------------
  // A service granted at cycle t0 occupies the ROM in cycles t0+1..t0+RD_LAT
  // and acks in cycle t0+RD_LAT+1; the cycle after that is free to grant.
  int          cyc;
  bit          m_pend [2];
  logic [18:0] m_paddr [2];
  int          m_starve;
  bit          m_active;
  int          m_t0;
  int          m_owner;
  logic [18:0] m_saddr;
  logic [18:0] m_memaddr;
  logic [7:0]  m_held [2];

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = 0; m_paddr[p] = '0; m_held[p] = '0;
    end
    m_starve = 0; m_active = 0; m_t0 = 0; m_owner = 0;
    m_saddr = '0; m_memaddr = '0;
  endtask

  task automatic model_step();
    int          ph, win;
    bit          op [2];
    bit          s [2];
    logic [18:0] a [2];
    logic [18:0] oa [2];
    ph = cyc - m_t0;
    s[0] = bus.cpu_stb; a[0] = bus.cpu_addr;
    s[1] = bus.dma_stb; a[1] = bus.dma_addr;
    for (int p = 0; p < 2; p++) begin op[p] = m_pend[p]; oa[p] = m_paddr[p]; end
    win = -1;
    if (!m_active && (op[0] || op[1]))
      win = (op[1] && (!op[0] || m_starve == SMAX)) ? 1 : 0;
    if (!op[1]) m_starve = 0;
    else if (win == 1) m_starve = 0;
    else if (win == 0 && m_starve < SMAX) m_starve++;
    for (int p = 0; p < 2; p++)
      if (s[p] && !op[p] && !(m_active && m_owner == p && ph <= RD_LAT)) begin
        m_pend[p] = 1; m_paddr[p] = a[p];
      end
    if (m_active && ph == RD_LAT + 1) begin
      m_held[m_owner] = rom(m_saddr);
      m_active = 0;
    end
    if (win >= 0) begin
      m_pend[win] = 0; m_active = 1; m_t0 = cyc; m_owner = win;
      m_saddr = oa[win]; m_memaddr = oa[win];
    end
    cyc++;
  endtask

  initial begin : compare
    int         ph;
    logic       e_ack [2];
    logic [7:0] e_dat [2];
    logic       e_cs, e_busy;
    cyc = 0;
    model_reset();
    forever begin
      @(negedge fclk);
      if (rst) model_reset();
      ph = cyc - m_t0;
      e_cs   = m_active && ph >= 1 && ph <= RD_LAT;
      e_busy = m_active || m_pend[0] || m_pend[1];
      for (int p = 0; p < 2; p++) begin
        e_ack[p] = m_active && ph == RD_LAT + 1 && m_owner == p;
        e_dat[p] = e_ack[p] ? rom(m_saddr) : m_held[p];
        if (e_ack[p])
          $display("cyc %0d %s read addr %h data %h", cyc, (p == 0) ? "cpu" : "dma",
                   m_saddr, e_dat[p]);
      end
      chk($sformatf("cpu_ack@%0d", cyc),   64'(bus.cpu_ack),   64'(e_ack[0]));
      chk($sformatf("dma_ack@%0d", cyc),   64'(bus.dma_ack),   64'(e_ack[1]));
      chk($sformatf("cpu_rdata@%0d", cyc), 64'(bus.cpu_rdata), 64'(e_dat[0]));
      chk($sformatf("dma_rdata@%0d", cyc), 64'(bus.dma_rdata), 64'(e_dat[1]));
      chk($sformatf("mem_cs@%0d", cyc),    64'(bus.mem_cs),    64'(e_cs));
      chk($sformatf("busy@%0d", cyc),      64'(bus.busy),      64'(e_busy));
      if (e_cs)
        chk($sformatf("mem_addr@%0d", cyc), 64'(bus.mem_addr), 64'(m_memaddr));
      @(posedge fclk);
      if (!rst) model_step();
    end
  end

  // ---------------- directed sequences ----------------
  logic        q_cstb [32];
  logic [18:0] q_caddr [32];
  logic        q_dstb [32];
  logic [18:0] q_daddr [32];
  logic        q_rst  [32];
  logic [31:0] w_cack, w_dack, w_cs, w_busy;
  logic [7:0]  w_cdat, w_ddat;

  task automatic clear_seq();
    for (int i = 0; i < 32; i++) begin
      q_cstb[i] = 0; q_caddr[i] = '0; q_dstb[i] = 0; q_daddr[i] = '0; q_rst[i] = 0;
    end
  endtask

  // Entered #1 after a rising edge; slot k is cycle k of the scenario.
  task automatic run_seq(input int n);
    w_cack = '0; w_dack = '0; w_cs = '0; w_busy = '0; w_cdat = '0; w_ddat = '0;
    for (int k = 0; k < n; k++) begin
      rst = q_rst[k];
      bus.cpu_stb = q_cstb[k]; bus.cpu_addr = q_caddr[k];
      bus.dma_stb = q_dstb[k]; bus.dma_addr = q_daddr[k];
      @(negedge fclk);
      w_cack[k] = bus.cpu_ack; w_dack[k] = bus.dma_ack;
      w_cs[k] = bus.mem_cs; w_busy[k] = bus.busy;
      if (bus.cpu_ack) w_cdat = bus.cpu_rdata;
      if (bus.dma_ack) w_ddat = bus.dma_rdata;
      @(posedge fclk); #1;
    end
    rst = 0; bus.cpu_stb = 0; bus.dma_stb = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  initial begin : stimulus
    bus.cpu_stb = 0; bus.cpu_addr = '0; bus.dma_stb = 0; bus.dma_addr = '0;
    idle(3);
    rst = 0;
    idle(3);

    // 1: reset state
    @(negedge fclk);
    chk("rst cpu_ack", 64'(bus.cpu_ack), 64'(0));
    chk("rst dma_ack", 64'(bus.dma_ack), 64'(0));
    chk("rst mem_cs",  64'(bus.mem_cs),  64'(0));
    chk("rst busy",    64'(bus.busy),    64'(0));
    chk("rst mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("rst rdata", 64'({bus.cpu_rdata, bus.dma_rdata}), 64'(0));
    @(posedge fclk); #1;

    // 2: single CPU read
    clear_seq(); q_cstb[0] = 1; q_caddr[0] = 19'h01234;
    run_seq(8);
    chk("t2 cpu_ack cycles", 64'(w_cack), 64'(32'h10));
    chk("t2 mem_cs cycles",  64'(w_cs),   64'(32'h0C));
    chk("t2 dma_ack cycles", 64'(w_dack), 64'(0));
    chk("t2 cpu_rdata",      64'(w_cdat), 64'(8'h26));

    // 3: simultaneous strobes, CPU first
    clear_seq();
    q_cstb[0] = 1; q_caddr[0] = 19'h00100;
    q_dstb[0] = 1; q_daddr[0] = 19'h7FF01;
    run_seq(10);
    chk("t3 cpu_ack cycles", 64'(w_cack), 64'(32'h10));
    chk("t3 dma_ack cycles", 64'(w_dack), 64'(32'h100));
    chk("t3 cpu_rdata",      64'(w_cdat), 64'(8'h01));
    chk("t3 dma_rdata",      64'(w_ddat), 64'(8'hFE));

    // 4: CPU re-strobes in each RESP, DMA gets in after 4 CPU grants
    clear_seq();
    q_dstb[0] = 1; q_daddr[0] = 19'h05A00;
    for (int k = 0; k <= 16; k += 4) begin
      q_cstb[k] = 1; q_caddr[k] = 19'(19'h00100 + k);
    end
    run_seq(28);
    chk("t4 cpu_ack cycles", 64'(w_cack), 64'(32'h01011110));
    chk("t4 dma_ack cycles", 64'(w_dack), 64'(32'h00100000));
    chk("t4 last cpu_rdata", 64'(w_cdat), 64'(8'h11));
    chk("t4 dma_rdata",      64'(w_ddat), 64'(8'h5A));

    // 5: second strobe during service is dropped
    clear_seq();
    q_cstb[0] = 1; q_caddr[0] = 19'h00010;
    q_cstb[2] = 1; q_caddr[2] = 19'h00020;
    run_seq(12);
    chk("t5 cpu_ack cycles", 64'(w_cack), 64'(32'h10));
    chk("t5 cpu_rdata",      64'(w_cdat), 64'(8'h10));

    // 6: reset in the middle of a DMA access, then a fresh request
    clear_seq();
    q_dstb[0] = 1; q_daddr[0] = 19'h12345; q_rst[3] = 1;
    run_seq(8);
    chk("t6 dma_ack cycles", 64'(w_dack), 64'(0));
    chk("t6 mem_cs cycles",  64'(w_cs),   64'(32'h04));
    chk("t6 busy before rst", 64'(w_busy & 32'h06), 64'(32'h06));
    chk("t6 busy after rst",  64'(w_busy & 32'hF8), 64'(0));
    clear_seq();
    q_dstb[0] = 1; q_daddr[0] = 19'h0ABCD;
    run_seq(6);
    chk("t6 fresh dma_ack cycles", 64'(w_dack), 64'(32'h10));
    chk("t6 fresh dma_rdata",      64'(w_ddat), 64'(8'h66));

    // Randomized traffic: saturating CPU, moderate CPU, light CPU.
    for (int phase = 0; phase < 3; phase++) begin
      for (int k = 0; k < 1500; k++) begin
        case (phase)
          0:       bus.cpu_stb = 1'b1;
          1:       bus.cpu_stb = 1'($urandom_range(0, 1));
          default: bus.cpu_stb = ($urandom_range(0, 4) == 0);
        endcase
        bus.cpu_addr = 19'($urandom);
        bus.dma_stb  = ($urandom_range(0, 4) == 0);
        bus.dma_addr = 19'($urandom);
        rst          = ($urandom_range(0, 399) == 0);
        @(posedge fclk); #1;
      end
    end
    rst = 0; bus.cpu_stb = 0; bus.dma_stb = 0;
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
